// File: rtl/seq_matmul_unit.sv
// -----------------------------------------------------------------------------
// seq_matmul_unit
//
// Sequential matrix multiplier, responder side of the start/done handshake
// used by the attention front-end.  A start pulse in IDLE snapshots A (MxK) and
// B (KxN), both signed Q1.15. The unit then computes C = A*B with one signed
// MAC per clock. Each finished element is saturated to signed Q2.30 and
// written into a held result array. When the last element is written, done
// pulses for one cycle.
//
// Latency: start is sampled at edge E0. The MACs run on edges E1..E(M*N*K).
// done is high in the cycle after E(M*N*K), and the unit then returns to IDLE.
//
// Optional feature (macro SEQ_MATMUL_PERF_EN):
//   defined   - perf_cycles counts edges spent in RUN or DONE. It saturates at
//               all-ones and clears only on reset.
//   undefined - perf_cycles is tied to zero and no counter is built.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   start        job request, sampled only in IDLE
//   a_in         A elements, row-major, index i*K+k      (DATA_WIDTH each)
//   b_in         B elements, row-major, index k*N+j      (DATA_WIDTH each)
//   c_out        C elements, row-major, index i*N+j      (OUT_WIDTH each)
//   done         one-cycle completion pulse
//   busy         high while in RUN or DONE
//   perf_cycles  busy-cycle counter (zero unless SEQ_MATMUL_PERF_EN)
// -----------------------------------------------------------------------------
module seq_matmul_unit #(
  parameter int M          = 8,
  parameter int K          = 8,
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a_in [M*K],
  input  logic [DATA_WIDTH-1:0] b_in [K*N],
  output logic [OUT_WIDTH-1:0]  c_out [M*N],
  output logic                  done,
  output logic                  busy,
  output logic [31:0]           perf_cycles
);

  // Product width is exact for two signed DATA_WIDTH operands.
  localparam int PW = 2 * DATA_WIDTH;

  // The accumulator is wide enough to hold K full-scale products, so it cannot
  // overflow before saturation.
  localparam int ACC_W = OUT_WIDTH + $clog2(K) + 1;

  localparam int IW  = (M > 1)     ? $clog2(M)     : 1;
  localparam int KW  = (K > 1)     ? $clog2(K)     : 1;
  localparam int JW  = (N > 1)     ? $clog2(N)     : 1;
  localparam int AIW = (M * K > 1) ? $clog2(M * K) : 1;
  localparam int BIW = (K * N > 1) ? $clog2(K * N) : 1;
  localparam int CIW = (M * N > 1) ? $clog2(M * N) : 1;

  localparam logic [IW-1:0] I_LAST = IW'(M - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N - 1);

  // Saturation bounds, sign-extended to the accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;

  logic signed [DATA_WIDTH-1:0] a_reg [M*K];
  logic signed [DATA_WIDTH-1:0] b_reg [K*N];

  logic [IW-1:0] i;
  logic [KW-1:0] k;
  logic [JW-1:0] j;

  logic signed [ACC_W-1:0] acc;

  logic [AIW-1:0] a_idx;
  logic [BIW-1:0] b_idx;
  logic [CIW-1:0] c_idx;

  logic signed [PW-1:0]        a_op;
  logic signed [PW-1:0]        b_op;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_W-1:0]     sum;
  logic        [OUT_WIDTH-1:0] sat_val;

  // Flat row-major addresses for the current (i, j, k) step.
  always_comb begin
    a_idx = AIW'(32'(i) * K + 32'(k));
    b_idx = BIW'(32'(k) * N + 32'(j));
    c_idx = CIW'(32'(i) * N + 32'(j));
  end

  // One MAC step. The sum always includes the current product. On the last k
  // step, the saturated sum is what gets written to c_out.
  always_comb begin
    a_op = PW'(a_reg[a_idx]);
    b_op = PW'(b_reg[b_idx]);
    prod = a_op * b_op;
    sum  = acc + ACC_W'(prod);
    if (sum > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_WIDTH-1:0];
    end else if (sum < SAT_MIN) begin
      sat_val = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      sat_val = sum[OUT_WIDTH-1:0];
    end
  end

  // Control, snapshot and result storage.
  // Results are not cleared at start. Each element is overwritten in place as
  // the new job reaches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      acc   <= '0;
      for (int n = 0; n < M * K; n++) a_reg[n] <= '0;
      for (int n = 0; n < K * N; n++) b_reg[n] <= '0;
      for (int n = 0; n < M * N; n++) c_out[n] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int n = 0; n < M * K; n++) a_reg[n] <= a_in[n];
            for (int n = 0; n < K * N; n++) b_reg[n] <= b_in[n];
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (k == K_LAST) begin
            c_out[c_idx] <= sat_val;
            acc          <= '0;
            k            <= '0;
            if (j == J_LAST) begin
              j <= '0;
              if (i == I_LAST) begin
                i     <= '0;
                state <= DONE;
              end else begin
                i <= i + IW'(1);
              end
            end else begin
              j <= j + JW'(1);
            end
          end else begin
            acc <= sum;
            k   <= k + KW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign done = (state == DONE);
  assign busy = (state == RUN) || (state == DONE);

`ifdef SEQ_MATMUL_PERF_EN
  // Busy-cycle counter. It accumulates across jobs and holds at all-ones
  // instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
    end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`else
  assign perf_cycles = '0;
`endif

endmodule
